// File: rtl/tetris_move_scheduler.sv
`default_nettype none
// ============================================================================
// tetris_move_scheduler
//   Debounces the left/right/rotate buttons, latches one pending request per
//   button plus a gravity (drop) request from a free-running tick counter, and
//   issues at most one single-cycle command at a time to the game core,
//   waiting for the core to go idle before the next one.
//   Optional feature macro: AUTO_REPEAT_EN (held left/right auto-repeat).
//   Revision: 1.0
// ============================================================================
module tetris_move_scheduler #(
  parameter int TICK_DIV   = 50,
  parameter int DEB_CYCLES = 4,
  parameter int REPEAT_CYC = 16
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_rotate,
  input  logic       pause,
  input  logic       core_busy,
  output logic       cmd_drop,
  output logic       cmd_rotate,
  output logic       cmd_left,
  output logic       cmd_right,
  output logic [7:0] lost_cnt
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
  localparam int RW = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYC - 1);
`endif

  // Flag bit order doubles as grant priority: lowest index wins.
  // [0] drop, [1] rotate, [2] left, [3] right
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     pend_q, pend_d;
  logic [3:0]     cmd_q, cmd_d;
  logic [7:0]     lost_q, lost_d;
  logic [TW-1:0]  grav_q, grav_d;
  logic           grav_wrap;
  logic [2:0]     raw;
  logic [2:0]     btn_set;
  logic [3:0]     set_vec;
  logic [3:0]     clr_vec;
  logic [3:0]     grant;
  logic           any_loss;

  // Button index: [0] rotate, [1] left, [2] right
  assign raw = {btn_right, btn_left, btn_rotate};

  for (genvar b = 0; b < 3; b++) begin : g_btn
    logic [DW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;
    logic          rise;

    // Debounce: the level follows raw only after DEB_CYCLES stable samples.
    always_comb begin
      cnt_d = cnt_q;
      lvl_d = lvl_q;
      rise  = 1'b0;
      if (raw[b] == lvl_q) begin
        cnt_d = '0;
      end else if (cnt_q == DEB_LAST) begin
        cnt_d = '0;
        lvl_d = raw[b];
        rise  = raw[b];
      end else begin
        cnt_d = cnt_q + DW'(1);
      end
    end

    // Debounce state registers.
    always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
        cnt_q <= '0;
        lvl_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        lvl_q <= lvl_d;
      end
    end

`ifdef AUTO_REPEAT_EN
    if (b == 0) begin : g_norep
      assign btn_set[b] = rise;
    end else begin : g_rep
      logic [RW-1:0] rc_q, rc_d;
      logic          fire;

      // Auto-repeat: re-request every REPEAT_CYC cycles while the level is held.
      always_comb begin
        rc_d = rc_q;
        fire = 1'b0;
        if (!lvl_q) begin
          rc_d = '0;
        end else if (rc_q == REP_LAST) begin
          rc_d = '0;
          fire = 1'b1;
        end else begin
          rc_d = rc_q + RW'(1);
        end
      end

      // Auto-repeat counter register.
      always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
          rc_q <= '0;
        end else begin
          rc_q <= rc_d;
        end
      end

      assign btn_set[b] = rise | fire;
    end
`else
    assign btn_set[b] = rise;
`endif
  end

  // Gravity counter: 0..TICK_DIV-1, frozen while paused; wrap requests a drop.
  always_comb begin
    grav_d    = grav_q;
    grav_wrap = 1'b0;
    if (!pause) begin
      if (grav_q == TICK_LAST) begin
        grav_d    = '0;
        grav_wrap = 1'b1;
      end else begin
        grav_d = grav_q + TW'(1);
      end
    end
  end

  // Pending flags: a set beats a same-cycle clear; a set onto a held flag is lost.
  always_comb begin
    set_vec  = {btn_set, grav_wrap};
    clr_vec  = (state_q == S_ISSUE) ? cmd_q : 4'b0000;
    pend_d   = set_vec | (pend_q & ~clr_vec);
    any_loss = |(set_vec & pend_q & ~clr_vec);
    lost_d   = (any_loss && (lost_q != 8'hFF)) ? (lost_q + 8'd1) : lost_q;
  end

  // Issue sequencer: grant by priority in IDLE, pulse in ISSUE, wait for core.
  always_comb begin
    state_d = state_q;
    cmd_d   = 4'b0000;
    grant   = pend_q & (~pend_q + 4'd1);
    case (state_q)
      S_IDLE: begin
        if (!pause && (|pend_q)) begin
          state_d = S_ISSUE;
          cmd_d   = grant;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (!core_busy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Core state registers.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      cmd_q   <= '0;
      lost_q  <= '0;
      grav_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cmd_q   <= cmd_d;
      lost_q  <= lost_d;
      grav_q  <= grav_d;
    end
  end

  assign cmd_drop   = cmd_q[0];
  assign cmd_rotate = cmd_q[1];
  assign cmd_left   = cmd_q[2];
  assign cmd_right  = cmd_q[3];
  assign lost_cnt   = lost_q;

endmodule
`default_nettype wire
